// File: rtl/seven_seg_pkg.sv
// Shared 7-segment definitions: active-high a..g glyph table, blank code and
// the readback checker state type. Also used by the display encoder.
package seven_seg_pkg;

    localparam int SEG_W      = 7;
    localparam int NUM_GLYPHS = 16;

    // Bit 6 = segment a ... bit 0 = segment g, 1 = segment lit.
    localparam logic [SEG_W-1:0] SEG_PATTERN [0:NUM_GLYPHS-1] = '{
        7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
        7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47
    };

    localparam logic [SEG_W-1:0] SEG_BLANK = 7'h00;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,   // blank pattern locked
        SETTLE = 2'd1,   // waiting for the pattern to stay put
        LOCKED = 2'd2    // valid digit or undecodable pattern locked
    } seg_state_e;

endpackage

// File: rtl/seg_pattern_decode.sv
// Combinational glyph decoder: active-high a..g pattern to hex value.
// hit is set only for one of the 16 table glyphs; the blank code is
// reported separately and is not a hit.
module seg_pattern_decode
    import seven_seg_pkg::*;
(
    input  logic [6:0] pattern,
    output logic       hit,
    output logic       is_blank,
    output logic [3:0] value
);

    // Table lookup; anything outside the 16 glyphs leaves hit low.
    always_comb begin
        hit      = 1'b0;
        value    = 4'h0;
        is_blank = (pattern == SEG_BLANK);
        case (pattern)
            SEG_PATTERN[0]:  begin hit = 1'b1; value = 4'h0; end
            SEG_PATTERN[1]:  begin hit = 1'b1; value = 4'h1; end
            SEG_PATTERN[2]:  begin hit = 1'b1; value = 4'h2; end
            SEG_PATTERN[3]:  begin hit = 1'b1; value = 4'h3; end
            SEG_PATTERN[4]:  begin hit = 1'b1; value = 4'h4; end
            SEG_PATTERN[5]:  begin hit = 1'b1; value = 4'h5; end
            SEG_PATTERN[6]:  begin hit = 1'b1; value = 4'h6; end
            SEG_PATTERN[7]:  begin hit = 1'b1; value = 4'h7; end
            SEG_PATTERN[8]:  begin hit = 1'b1; value = 4'h8; end
            SEG_PATTERN[9]:  begin hit = 1'b1; value = 4'h9; end
            SEG_PATTERN[10]: begin hit = 1'b1; value = 4'hA; end
            SEG_PATTERN[11]: begin hit = 1'b1; value = 4'hB; end
            SEG_PATTERN[12]: begin hit = 1'b1; value = 4'hC; end
            SEG_PATTERN[13]: begin hit = 1'b1; value = 4'hD; end
            SEG_PATTERN[14]: begin hit = 1'b1; value = 4'hE; end
            SEG_PATTERN[15]: begin hit = 1'b1; value = 4'hF; end
            default:         begin hit = 1'b0; value = 4'h0; end
        endcase
    end

endmodule

// File: rtl/seven_segment_to_binary.sv
// Readback checker for the active-low 7-segment display bus. Synchronises
// the bus, waits for the pattern to hold for STABLE_CYCLES+1 samples, then
// reports the decoded hex digit, a blank display or an undecodable pattern.
module seven_segment_to_binary
    import seven_seg_pkg::*;
#(
    parameter int STABLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] seg_n,
    output logic [3:0] binary_out,
    output logic       digit_valid,
    output logic       new_digit,
    output logic       blank,
    output logic       pattern_error
);

    localparam int             CNT_W    = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    logic [6:0]       sync1_q, sync1_d;
    logic [6:0]       sync2_q, sync2_d;
    logic [6:0]       candidate_q, candidate_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    seg_state_e       state_q, state_d;
    logic [3:0]       binary_out_q, binary_out_d;
    logic             digit_valid_q, digit_valid_d;
    logic             new_digit_q, new_digit_d;
    logic             blank_q, blank_d;
    logic             pattern_error_q, pattern_error_d;

    logic [6:0]       sample_s;
    logic             dec_hit_s;
    logic             dec_blank_s;
    logic [3:0]       dec_value_s;

    // Active-high view of the synchronised bus.
    assign sample_s = ~sync2_q;

    // Lock decisions are made on the candidate, which equals the sample
    // whenever a lock can happen.
    seg_pattern_decode u_decode (
        .pattern  (candidate_q),
        .hit      (dec_hit_s),
        .is_blank (dec_blank_s),
        .value    (dec_value_s)
    );

    // Next-state: synchroniser shift, stability counting and lock decode.
    always_comb begin
        sync1_d         = seg_n;
        sync2_d         = sync1_q;
        candidate_d     = candidate_q;
        cnt_d           = cnt_q;
        state_d         = state_q;
        binary_out_d    = binary_out_q;
        digit_valid_d   = digit_valid_q;
        new_digit_d     = 1'b0;
        blank_d         = blank_q;
        pattern_error_d = pattern_error_q;

        if (sample_s != candidate_q) begin
            // Any change restarts settling; the last digit is kept on binary_out.
            candidate_d     = sample_s;
            cnt_d           = '0;
            state_d         = SETTLE;
            digit_valid_d   = 1'b0;
            blank_d         = 1'b0;
            pattern_error_d = 1'b0;
        end else begin
            case (state_q)
                SETTLE: begin
                    if (cnt_q == CNT_LAST) begin
                        if (dec_hit_s) begin
                            binary_out_d  = dec_value_s;
                            digit_valid_d = 1'b1;
                            new_digit_d   = 1'b1;
                            state_d       = LOCKED;
                        end else if (dec_blank_s) begin
                            blank_d = 1'b1;
                            state_d = IDLE;
                        end else begin
                            pattern_error_d = 1'b1;
                            state_d         = LOCKED;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                IDLE, LOCKED: begin
                    // Stable and already reported: everything holds.
                    state_d = state_q;
                end
                default: begin
                    // Unreachable encoding: re-qualify the current pattern.
                    state_d         = SETTLE;
                    cnt_d           = '0;
                    digit_valid_d   = 1'b0;
                    blank_d         = 1'b0;
                    pattern_error_d = 1'b0;
                end
            endcase
        end
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q         <= 7'h7F;
            sync2_q         <= 7'h7F;
            candidate_q     <= SEG_BLANK;
            cnt_q           <= '0;
            state_q         <= IDLE;
            binary_out_q    <= 4'h0;
            digit_valid_q   <= 1'b0;
            new_digit_q     <= 1'b0;
            blank_q         <= 1'b1;
            pattern_error_q <= 1'b0;
        end else begin
            sync1_q         <= sync1_d;
            sync2_q         <= sync2_d;
            candidate_q     <= candidate_d;
            cnt_q           <= cnt_d;
            state_q         <= state_d;
            binary_out_q    <= binary_out_d;
            digit_valid_q   <= digit_valid_d;
            new_digit_q     <= new_digit_d;
            blank_q         <= blank_d;
            pattern_error_q <= pattern_error_d;
        end
    end

    assign binary_out    = binary_out_q;
    assign digit_valid   = digit_valid_q;
    assign new_digit     = new_digit_q;
    assign blank         = blank_q;
    assign pattern_error = pattern_error_q;

endmodule

// File: tb/tb_seven_segment_to_binary.sv
// Self-checking bench for seven_segment_to_binary. A run-length reference
// model (pattern must be seen STABLE_CYCLES+1 samples in a row, two cycles
// after it appears on the pins) predicts every output each cycle.
module tb_seven_segment_to_binary;

    localparam int S = 4;

    // Independent copy of the glyph table (active-high a..g).
    localparam logic [6:0] TB_TAB [16] = '{
        7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
        7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47
    };

    logic       clk = 1'b0;
    logic       rst_n;
    logic [6:0] seg_n;
    logic [3:0] binary_out;
    logic       digit_valid;
    logic       new_digit;
    logic       blank;
    logic       pattern_error;

    seven_segment_to_binary #(.STABLE_CYCLES(S)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .seg_n         (seg_n),
        .binary_out    (binary_out),
        .digit_valid   (digit_valid),
        .new_digit     (new_digit),
        .blank         (blank),
        .pattern_error (pattern_error)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int pulse_cnt = 0;

    // Reference model state
    logic [6:0] m_pin1, m_pin2;   // pin values seen at the last two edges
    logic [6:0] m_prev;           // last active-high sample
    int         m_run;            // consecutive identical samples
    logic [3:0] e_bin;
    logic       e_valid, e_pulse, e_blank, e_err;

    task automatic chk(input string tag, input logic [6:0] obs, input logic [6:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pin1 = 7'h7F; m_pin2 = 7'h7F;
        m_prev = 7'h00; m_run = S + 1;
        e_bin = 4'h0; e_valid = 1'b0; e_pulse = 1'b0; e_blank = 1'b1; e_err = 1'b0;
    endtask

    // One clock edge of the reference model; pins reach the decision two edges late.
    task automatic model_edge();
        logic [6:0] smp;
        bit         found;
        smp = ~m_pin2;
        m_pin2 = m_pin1;
        m_pin1 = seg_n;
        e_pulse = 1'b0;
        if (smp != m_prev) begin
            m_prev = smp; m_run = 1;
            e_valid = 1'b0; e_blank = 1'b0; e_err = 1'b0;
        end else if (m_run <= S) begin
            m_run++;
            if (m_run == S + 1) begin
                found = 1'b0;
                for (int k = 0; k < 16; k++) begin
                    if (TB_TAB[k] == smp) begin
                        found = 1'b1; e_bin = 4'(k);
                    end
                end
                if (found) begin
                    e_valid = 1'b1; e_pulse = 1'b1;
                end else if (smp == 7'h00) begin
                    e_blank = 1'b1;
                end else begin
                    e_err = 1'b1;
                end
            end
        end
    endtask

    task automatic check_all();
        chk("binary_out",    7'(binary_out),    7'(e_bin));
        chk("digit_valid",   7'(digit_valid),   7'(e_valid));
        chk("new_digit",     7'(new_digit),     7'(e_pulse));
        chk("blank",         7'(blank),         7'(e_blank));
        chk("pattern_error", 7'(pattern_error), 7'(e_err));
        if (new_digit === 1'b1) pulse_cnt++;
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            model_edge();
            @(negedge clk);
            check_all();
        end
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_bin"},   7'(binary_out),    7'h00);
        chk({tag, "_dv"},    7'(digit_valid),   7'h00);
        chk({tag, "_nd"},    7'(new_digit),     7'h00);
        chk({tag, "_blank"}, 7'(blank),         7'h01);
        chk({tag, "_perr"},  7'(pattern_error), 7'h00);
    endtask

    initial begin
        int kind;
        int hold;
        logic [6:0] pat;

        // Reset with a dark display
        rst_n = 1'b0;
        seg_n = 7'h7F;
        model_reset();
        @(posedge clk);
        @(negedge clk);
        check_reset_values("reset");
        rst_n = 1'b1;
        pulse_cnt = 0;
        step(8);
        chk("blank_no_pulse", 7'(pulse_cnt), 7'd0);

        // Digit 1 from blank: latency of each output
        seg_n = 7'h4F;
        step(2);
        chk("d1_blank_hold", 7'(blank), 7'h01);
        step(1);
        chk("d1_blank_fall", 7'(blank), 7'h00);
        step(3);
        chk("d1_dv_early", 7'(digit_valid), 7'h00);
        step(1);
        chk("d1_dv_rise", 7'(digit_valid), 7'h01);
        chk("d1_pulse",   7'(new_digit),   7'h01);
        chk("d1_value",   7'(binary_out),  7'h01);
        step(1);
        chk("d1_pulse_end", 7'(new_digit), 7'h00);

        // Sweep all 16 glyphs
        pulse_cnt = 0;
        for (int i = 0; i < 16; i++) begin
            pat   = TB_TAB[i];
            seg_n = ~pat;
            step(10);
            chk("sweep_value", 7'(binary_out), 7'(i));
        end
        chk("sweep_pulses", 7'(pulse_cnt), 7'd16);

        // Glitch on a locked 8
        seg_n = 7'h00;
        step(10);
        pulse_cnt = 0;
        seg_n = 7'h01;
        step(2);
        seg_n = 7'h00;
        step(6);
        chk("glitch_dv_low", 7'(digit_valid), 7'h00);
        chk("glitch_bin",    7'(binary_out),  7'h08);
        step(1);
        chk("glitch_dv_relock", 7'(digit_valid), 7'h01);
        step(3);
        chk("glitch_one_pulse", 7'(pulse_cnt), 7'd1);

        // Undecodable pattern (only segment g lit)
        seg_n = 7'h7E;
        step(6);
        chk("perr_early", 7'(pattern_error), 7'h00);
        step(1);
        chk("perr_set", 7'(pattern_error), 7'h01);
        chk("perr_dv",  7'(digit_valid),   7'h00);
        chk("perr_bin", 7'(binary_out),    7'h08);
        step(3);

        // Reset while settling at cnt=2
        pat   = TB_TAB[5];
        seg_n = ~pat;
        step(5);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_values("midreset");
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        pulse_cnt = 0;
        step(8);
        chk("midreset_relock", 7'(digit_valid), 7'h01);
        chk("midreset_value",  7'(binary_out),  7'h05);
        chk("midreset_pulse",  7'(pulse_cnt),   7'd1);

        // Randomised bus activity
        for (int t = 0; t < 300; t++) begin
            kind = int'($urandom_range(0, 9));
            if (kind <= 6) begin
                pat = TB_TAB[$urandom_range(0, 15)];
            end else if (kind == 7) begin
                pat = 7'h00;
            end else begin
                pat = 7'($urandom);
            end
            seg_n = ~pat;
            hold  = int'($urandom_range(1, 9));
            step(hold);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
